mc_datapath: RTL and testbench



---
 rtl/mc_datapath.sv | 217 +++++++++++++++++++++
 tb/tb_mc_datapath.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath: PC, IR, 32x32 register file, ALU and FSM sharing one req/ready memory port.
// Optional write/store trace: define MC_DATAPATH_TRACE_EN.
module mc_datapath #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        bus_err
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d, wait_q, wait_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] rf_q [32];

    logic        mem_req_c, mem_we_c, retire_c, wb_en_c, timeout_hit;
    logic [31:0] mem_addr_c, wb_data_c;
    logic [4:0]  wb_addr_c;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] sext_imm, pc_plus4, br_target, j_target, rd_a, rd_b;
    logic        is_zero, is_r, is_addu, is_subu, is_slt, is_jr;
    logic        is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

    assign op        = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign funct     = ir_q[5:0];
    assign imm       = ir_q[15:0];
    assign sext_imm  = {{16{imm[15]}}, imm};
    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {sext_imm[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    assign rd_a      = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rd_b      = (rt == 5'd0) ? 32'd0 : rf_q[rt];

    // The all-zero word is an explicit nop even though it decodes as an R-type.
    assign is_zero = (ir_q == 32'd0);
    assign is_r    = (op == 6'h00) && !is_zero;
    assign is_addu = is_r && (funct == 6'h21);
    assign is_subu = is_r && (funct == 6'h23);
    assign is_slt  = is_r && (funct == 6'h2A);
    assign is_jr   = is_r && (funct == 6'h08);
    assign is_ori  = (op == 6'h0D);
    assign is_lui  = (op == 6'h0F);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign is_beq  = (op == 6'h04);
    assign is_j    = (op == 6'h02);
    assign is_jal  = (op == 6'h03);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_d       = alu_q;
        mdr_d       = mdr_q;
        wait_d      = wait_q;
        bus_err_d   = bus_err_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = pc_q;
        retire_c    = 1'b0;
        wb_en_c     = 1'b0;
        wb_addr_c   = 5'd0;
        wb_data_c   = alu_q;
        timeout_hit = 1'b0;

        if (state_q == FETCH) begin
            mem_req_c = 1'b1;
        end else if (state_q == MEM) begin
            mem_req_c  = 1'b1;
            mem_addr_c = alu_q;
            mem_we_c   = is_sw;
        end

        // Wait counter tracks consecutive stalled request cycles.
        if (mem_req_c) begin
            if (mem_ready) begin
                wait_d = 32'd0;
            end else begin
                wait_d      = wait_q + 32'd1;
                timeout_hit = (MEM_TIMEOUT != 0) && (wait_d == 32'(MEM_TIMEOUT));
            end
        end

        case (state_q)
            FETCH: begin
                if (timeout_hit) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end else if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = rd_a;
                b_d     = rd_b;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = WB;
                if (is_addu)            alu_d = a_q + b_q;
                else if (is_subu)       alu_d = a_q - b_q;
                else if (is_slt)        alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
                else if (is_ori)        alu_d = a_q | {16'd0, imm};
                else if (is_lui)        alu_d = {imm, 16'd0};
                else if (is_lw || is_sw) begin
                    alu_d   = a_q + sext_imm;
                    state_d = MEM;
                end else begin
                    retire_c = 1'b1;
                    state_d  = FETCH;
                    if (is_beq)              pc_d = (a_q == b_q) ? br_target : pc_plus4;
                    else if (is_j || is_jal) pc_d = j_target;
                    else if (is_jr)          pc_d = a_q;
                    else                     pc_d = pc_plus4;
                    if (is_jal) begin
                        wb_en_c   = 1'b1;
                        wb_addr_c = 5'd31;
                        wb_data_c = pc_plus4;
                    end
                end
            end
            MEM: begin
                if (timeout_hit) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end else if (mem_ready) begin
                    if (is_sw) begin
                        retire_c = 1'b1;
                        pc_d     = pc_plus4;
                        state_d  = FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                retire_c  = 1'b1;
                pc_d      = pc_plus4;
                state_d   = FETCH;
                wb_addr_c = is_r ? rd : rt;
                wb_data_c = is_lw ? mdr_q : alu_q;
                wb_en_c   = (wb_addr_c != 5'd0);
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_q     <= 32'd0;
            mdr_q     <= 32'd0;
            wait_q    <= 32'd0;
            bus_err_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            if (wb_en_c) rf_q[wb_addr_c] <= wb_data_c;
        end
    end

    assign mem_req   = mem_req_c & ~reset;
    assign mem_we    = mem_we_c;
    assign mem_addr  = mem_addr_c;
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign retire    = retire_c & ~reset;
    assign wb_en     = wb_en_c & ~reset;
    assign wb_addr   = wb_addr_c;
    assign wb_data   = wb_data_c;
    assign bus_err   = bus_err_q;

`ifdef MC_DATAPATH_TRACE_EN
    always_ff @(posedge clk) begin
        if (wb_en) $display("@%h: $%d <= %h", pc, wb_addr, wb_data);
        if (mem_req && mem_ready && mem_we) $display("@%h: *%h <= %h", pc, mem_addr, mem_wdata);
    end
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: small programs on a wait-state memory model, plus timeout/halt.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, wb_en, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, wb_data;
    logic [4:0]  wb_addr;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] imem [0:1023];
    logic [31:0] dmem [0:63];
    int          wait_n = 0;
    logic        stall = 1'b0;
    int          wcnt = 0;
    logic [31:0] st_addr = 32'd0;
    logic [31:0] st_data = 32'd0;

    always #5 clk = ~clk;

    mc_datapath #(.RESET_PC(32'h0000_3000), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .retire(retire), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .bus_err(bus_err)
    );

    // Memory model: instructions at 0x3000.., data below 0x100; wait_n stall cycles per access.
    assign mem_ready = mem_req && !stall && (wcnt >= wait_n);
    assign mem_rdata = mem_addr[12] ? imem[mem_addr[11:2]] : dmem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (mem_req && mem_ready && mem_we) begin
            dmem[mem_addr[7:2]] <= mem_wdata;
            st_addr <= mem_addr;
            st_data <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction to its retire cycle and checks length, write-back and next pc.
    task automatic run_instr(input string tag, input int exp_cyc, input logic exp_we,
                             input logic [4:0] exp_wa, input logic [31:0] exp_wd,
                             input logic [31:0] exp_pc);
        int          cyc = 0;
        logic        done = 1'b0;
        logic        we_s = 1'bx;
        logic [4:0]  wa_s = 5'bx;
        logic [31:0] wd_s = 32'bx;
        while (!done && cyc < 40) begin
            cyc++;
            if (retire) begin
                done = 1'b1;
                we_s = wb_en;
                wa_s = wb_addr;
                wd_s = wb_data;
            end
            step();
        end
        chk({tag, "_retired"}, {31'd0, done}, 32'd1);
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_wb_en"}, {31'd0, we_s}, {31'd0, exp_we});
        if (exp_we) begin
            chk({tag, "_wb_addr"}, {27'd0, wa_s}, {27'd0, exp_wa});
            chk({tag, "_wb_data"}, wd_s, exp_wd);
        end
        chk({tag, "_pc"}, pc, exp_pc);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        imem[0]  = 32'h3401_1234;  // ori  $1,$0,0x1234
        imem[1]  = 32'h3C02_FFFF;  // lui  $2,0xFFFF
        imem[2]  = 32'hAC02_0008;  // sw   $2,8($0)
        imem[3]  = 32'h8C03_0008;  // lw   $3,8($0)
        imem[4]  = 32'h3465_FFFF;  // ori  $5,$3,0xFFFF
        imem[5]  = 32'h3406_0001;  // ori  $6,$0,1
        imem[6]  = 32'h00A6_202A;  // slt  $4,$5,$6
        imem[7]  = 32'h00C5_382A;  // slt  $7,$6,$5
        imem[8]  = 32'h00C5_5023;  // subu $10,$6,$5
        imem[9]  = 32'h0021_0021;  // addu $0,$1,$1
        imem[10] = 32'h0000_4821;  // addu $9,$0,$0
        imem[11] = 32'h10C0_0005;  // beq  $6,$0,5 (not taken)
        imem[12] = 32'h0023_5821;  // addu $11,$1,$3
        step();
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        step();
        release_reset();
        chk("fetch0_req", {31'd0, mem_req}, 32'd1);
        chk("fetch0_addr", mem_addr, 32'h0000_3000);
        chk("fetch0_we", {31'd0, mem_we}, 32'd0);

        run_instr("ori1", 4, 1'b1, 5'd1, 32'h0000_1234, 32'h0000_3004);
        wait_n = 2;
        run_instr("lui2", 6, 1'b1, 5'd2, 32'hFFFF_0000, 32'h0000_3008);
        run_instr("sw", 8, 1'b0, 5'd0, 32'd0, 32'h0000_300C);
        chk("sw_addr", st_addr, 32'h0000_0008);
        chk("sw_data", st_data, 32'hFFFF_0000);
        run_instr("lw3", 9, 1'b1, 5'd3, 32'hFFFF_0000, 32'h0000_3010);
        wait_n = 0;
        run_instr("ori5", 4, 1'b1, 5'd5, 32'hFFFF_FFFF, 32'h0000_3014);
        run_instr("ori6", 4, 1'b1, 5'd6, 32'h0000_0001, 32'h0000_3018);
        run_instr("slt_neg_lt_pos", 4, 1'b1, 5'd4, 32'h0000_0001, 32'h0000_301C);
        run_instr("slt_pos_lt_neg", 4, 1'b1, 5'd7, 32'h0000_0000, 32'h0000_3020);
        run_instr("subu10", 4, 1'b1, 5'd10, 32'h0000_0002, 32'h0000_3024);
        run_instr("addu_r0", 4, 1'b0, 5'd0, 32'd0, 32'h0000_3028);
        run_instr("r0_reads0", 4, 1'b1, 5'd9, 32'h0000_0000, 32'h0000_302C);
        run_instr("beq_nt", 3, 1'b0, 5'd0, 32'd0, 32'h0000_3030);
        run_instr("addu11", 4, 1'b1, 5'd11, 32'hFFFF_1234, 32'h0000_3034);

        // Reset in the middle of a fetch, then jal/jr.
        chk("mid_fetch_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0000_3000);
        imem[0] = 32'h0C00_0C01;  // jal 0x0C01
        imem[1] = 32'h03E0_0008;  // jr  $31
        step();
        release_reset();
        run_instr("jal", 3, 1'b1, 5'd31, 32'h0000_3004, 32'h0000_3004);
        run_instr("jr", 3, 1'b0, 5'd0, 32'd0, 32'h0000_3004);

        // Nops then a beq that branches to itself.
        reset = 1'b1;
        imem[0] = 32'h0000_0000;
        imem[1] = 32'h0000_0000;
        imem[2] = 32'hFFFF_FFFF;  // unknown opcode
        imem[3] = 32'h0000_0000;
        imem[4] = 32'h1000_FFFF;  // beq $0,$0,-1
        step();
        release_reset();
        run_instr("nop0", 3, 1'b0, 5'd0, 32'd0, 32'h0000_3004);
        run_instr("nop1", 3, 1'b0, 5'd0, 32'd0, 32'h0000_3008);
        run_instr("unknown", 3, 1'b0, 5'd0, 32'd0, 32'h0000_300C);
        run_instr("nop3", 3, 1'b0, 5'd0, 32'd0, 32'h0000_3010);
        run_instr("beq_self", 3, 1'b0, 5'd0, 32'd0, 32'h0000_3010);
        run_instr("beq_self2", 3, 1'b0, 5'd0, 32'd0, 32'h0000_3010);

        // Memory never answers: halt after four wait cycles.
        reset = 1'b1;
        stall = 1'b1;
        imem[0] = 32'h3401_1234;
        step();
        release_reset();
        step();
        step();
        step();
        chk("to_wait3_req", {31'd0, mem_req}, 32'd1);
        chk("to_wait3_addr", mem_addr, 32'h0000_3000);
        chk("to_wait3_err", {31'd0, bus_err}, 32'd0);
        step();
        chk("to_err", {31'd0, bus_err}, 32'd1);
        chk("to_req_low", {31'd0, mem_req}, 32'd0);
        chk("to_pc", pc, 32'h0000_3000);
        stall = 1'b0;
        step();
        step();
        step();
        chk("halt_err_sticky", {31'd0, bus_err}, 32'd1);
        chk("halt_req_low", {31'd0, mem_req}, 32'd0);
        chk("halt_no_retire", {31'd0, retire}, 32'd0);
        reset = 1'b1;
        #1;
        chk("halt_rst_err", {31'd0, bus_err}, 32'd0);
        step();
        release_reset();
        chk("restart_req", {31'd0, mem_req}, 32'd1);
        chk("restart_addr", mem_addr, 32'h0000_3000);
        run_instr("restart_ori", 4, 1'b1, 5'd1, 32'h0000_1234, 32'h0000_3004);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
